// File: rtl/matvec_pkg.sv
// Shared types and constants for the sequenced 4x4 matrix-vector multiplier.
package matvec_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int MAT_ROWS   = 4;
    localparam int MAT_COLS   = 4;
    localparam int MAC_CYCLES = MAT_ROWS * MAT_COLS;

    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
    } rc_t;

    // The MAC index walks A in row-major order, so row/col are just its bit fields.
    function automatic rc_t idx_to_rc(input logic [3:0] idx);
        rc_t rc;
        rc.row = idx[3:2];
        rc.col = idx[1:0];
        return rc;
    endfunction

endpackage

// File: rtl/matvec_mac.sv
// Combinational N x N unsigned multiply, zero-extended and added to an accumulator.
module matvec_mac #(
    parameter int N     = 4,
    parameter int ACC_W = 2*N+2
) (
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     x,
    input  logic [ACC_W-1:0] acc_in,
    output logic [ACC_W-1:0] acc_out
);

    logic [2*N-1:0] prod;

    assign prod    = a * x;
    assign acc_out = acc_in + ACC_W'(prod);

endmodule

// File: rtl/matvec_sequencer.sv
// Y = A*X with one shared MAC over 16 cycles, start/done handshake.
// Optional y_ovf output (results that exceed 2N bits) when MATVEC_OVF_EN is defined.
module matvec_sequencer
    import matvec_pkg::*;
#(
    parameter int N     = 4,
    parameter int ACC_W = 2*N+2
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 start,
    input  logic [16*N-1:0]      a_flat,
    input  logic [4*N-1:0]       x_flat,
    output logic                 busy,
    output logic                 done,
`ifdef MATVEC_OVF_EN
    output logic [3:0]           y_ovf,
`endif
    output logic [4*ACC_W-1:0]   y_flat
);

    state_t state, state_nxt;
    logic   load, last;

    logic [3:0]                        index;
    logic [16*N-1:0]                   a_q;
    logic [4*N-1:0]                    x_q;
    logic [MAT_ROWS-1:0][ACC_W-1:0]    acc, acc_nxt;
    logic [4*ACC_W-1:0]                y_nxt;

    rc_t              rc;
    logic [N-1:0]     a_sel, x_sel;
    logic [ACC_W-1:0] mac_out;

    always_ff @(posedge clk) begin
        if (!clear) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        last      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (index == 4'(MAC_CYCLES-1)) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Element index into the latched matrix matches the MAC index (A11 in the MSBs).
    assign rc    = idx_to_rc(index);
    assign a_sel = a_q[(MAC_CYCLES-1-int'(index))*N +: N];
    assign x_sel = x_q[(MAT_COLS-1-int'(rc.col))*N +: N];

    matvec_mac #(.N(N), .ACC_W(ACC_W)) u_mac (
        .a       (a_sel),
        .x       (x_sel),
        .acc_in  (acc[rc.row]),
        .acc_out (mac_out)
    );

    always_comb begin
        acc_nxt         = acc;
        acc_nxt[rc.row] = mac_out;
        y_nxt           = '0;
        for (int i = 0; i < MAT_ROWS; i++)
            y_nxt[(MAT_ROWS-1-i)*ACC_W +: ACC_W] = acc_nxt[i];
    end

`ifdef MATVEC_OVF_EN
    localparam logic [ACC_W:0] OVF_LIM = (ACC_W+1)'(1) << (2*N);
    logic [3:0] ovf_nxt;

    always_comb begin
        ovf_nxt = '0;
        for (int i = 0; i < MAT_ROWS; i++)
            ovf_nxt[MAT_ROWS-1-i] = ({1'b0, acc_nxt[i]} >= OVF_LIM);
    end

    always_ff @(posedge clk) begin
        if (!clear)    y_ovf <= '0;
        else if (last) y_ovf <= ovf_nxt;
    end
`endif

    always_ff @(posedge clk) begin
        if (!clear) begin
            index  <= '0;
            a_q    <= '0;
            x_q    <= '0;
            acc    <= '0;
            y_flat <= '0;
        end else if (load) begin
            a_q   <= a_flat;
            x_q   <= x_flat;
            acc   <= '0;
            index <= '0;
        end else if (state == RUN) begin
            acc   <= acc_nxt;
            index <= index + 4'd1;
            // Final product is folded in here so y_flat is complete in the DONE cycle.
            if (last) y_flat <= y_nxt;
        end
    end

endmodule

// File: tb/tb_matvec_sequencer.sv
// Directed self-checking bench for matvec_sequencer (N=4, ACC_W=10).
module tb_matvec_sequencer;

    localparam int N     = 4;
    localparam int ACC_W = 2*N+2;

    logic               clk = 1'b0;
    logic               clear;
    logic               start;
    logic [16*N-1:0]    a_flat;
    logic [4*N-1:0]     x_flat;
    logic               busy;
    logic               done;
    logic [4*ACC_W-1:0] y_flat;
`ifdef MATVEC_OVF_EN
    logic [3:0]         y_ovf;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    matvec_sequencer #(.N(N), .ACC_W(ACC_W)) dut (
        .clk    (clk),
        .clear  (clear),
        .start  (start),
        .a_flat (a_flat),
        .x_flat (x_flat),
        .busy   (busy),
        .done   (done),
`ifdef MATVEC_OVF_EN
        .y_ovf  (y_ovf),
`endif
        .y_flat (y_flat)
    );

    function automatic logic [4*ACC_W-1:0] pack_y(input int y1, input int y2, input int y3, input int y4);
        return {ACC_W'(y1), ACC_W'(y2), ACC_W'(y3), ACC_W'(y4)};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue a one-cycle start; returns at the negedge after the accepting edge.
    task automatic launch(input logic [16*N-1:0] a, input logic [4*N-1:0] x);
        a_flat = a;
        x_flat = x;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // Count busy cycles (bounded) and stop at the first non-busy cycle.
    task automatic count_busy(output int nbusy);
        nbusy = 0;
        while (busy && nbusy < 40) begin
            nbusy++;
            tick();
        end
    endtask

    task automatic test_reset();
        clear  = 1'b0;
        start  = 1'b0;
        a_flat = '0;
        x_flat = '0;
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (y_flat !== '0) begin errors++; $display("FAIL reset_y got=%h exp=0", y_flat); end
`ifdef MATVEC_OVF_EN
        checks++; if (y_ovf !== 4'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", y_ovf); end
`endif
        clear = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int nb;
        launch({4{16'h1234}}, 16'h1111);
        count_busy(nb);
        checks++; if (nb !== 16) begin errors++; $display("FAIL basic_busy_len got=%0d exp=16", nb); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done got=%b exp=1", done); end
        checks++; if (y_flat !== pack_y(10, 10, 10, 10)) begin errors++; $display("FAIL basic_y got=%h exp=%h", y_flat, pack_y(10, 10, 10, 10)); end
`ifdef MATVEC_OVF_EN
        checks++; if (y_ovf !== 4'b0000) begin errors++; $display("FAIL basic_ovf got=%b exp=0000", y_ovf); end
`endif
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_idle got=busy%b/done%b exp=0/0", busy, done); end
    endtask

    task automatic test_max();
        int nb;
        launch({16{4'hF}}, 16'hFFFF);
        count_busy(nb);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL max_done got=%b exp=1", done); end
        checks++; if (y_flat !== pack_y(900, 900, 900, 900)) begin errors++; $display("FAIL max_y got=%h exp=%h", y_flat, pack_y(900, 900, 900, 900)); end
`ifdef MATVEC_OVF_EN
        checks++; if (y_ovf !== 4'b1111) begin errors++; $display("FAIL max_ovf got=%b exp=1111", y_ovf); end
`endif
        tick();
    endtask

    task automatic test_isolation();
        int  nb;
        logic [4*ACC_W-1:0] prev;
        prev = y_flat;
        launch(64'h1000_0100_0010_0001, 16'h5678);
        x_flat = '0;
        a_flat = {16{4'hF}};
        nb = 0;
        while (busy && nb < 40) begin
            checks++; if (y_flat !== prev) begin errors++; $display("FAIL iso_hold cyc=%0d got=%h exp=%h", nb, y_flat, prev); end
            nb++;
            tick();
        end
        checks++; if (nb !== 16) begin errors++; $display("FAIL iso_busy_len got=%0d exp=16", nb); end
        checks++; if (y_flat !== pack_y(5, 6, 7, 8)) begin errors++; $display("FAIL iso_y got=%h exp=%h", y_flat, pack_y(5, 6, 7, 8)); end
        tick();
    endtask

    task automatic test_start_ignored();
        int nb;
        int ndone;
        launch({16{4'h1}}, 16'h2222);
        nb    = 0;
        ndone = 0;
        while (busy && nb < 40) begin
            start = (nb >= 3 && nb <= 8);
            nb++;
            tick();
        end
        start = 1'b0;
        checks++; if (nb !== 16) begin errors++; $display("FAIL ign_busy_len got=%0d exp=16", nb); end
        checks++; if (y_flat !== pack_y(8, 8, 8, 8)) begin errors++; $display("FAIL ign_y got=%h exp=%h", y_flat, pack_y(8, 8, 8, 8)); end
        for (int i = 0; i < 20; i++) begin
            if (done) ndone++;
            tick();
        end
        checks++; if (ndone !== 1) begin errors++; $display("FAIL ign_done_count got=%0d exp=1", ndone); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_no_restart got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        int nb;
        launch({4{16'h1234}}, 16'h1111);
        count_busy(nb);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done got=%b exp=1", done); end
        checks++; if (y_flat !== pack_y(10, 10, 10, 10)) begin errors++; $display("FAIL b2b_first_y got=%h exp=%h", y_flat, pack_y(10, 10, 10, 10)); end
        launch(64'h1000_0100_0010_0001, 16'h1234);
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_restart got=busy%b/done%b exp=1/0", busy, done); end
        count_busy(nb);
        checks++; if (nb !== 16) begin errors++; $display("FAIL b2b_busy_len got=%0d exp=16", nb); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_second_done got=%b exp=1", done); end
        checks++; if (y_flat !== pack_y(1, 2, 3, 4)) begin errors++; $display("FAIL b2b_second_y got=%h exp=%h", y_flat, pack_y(1, 2, 3, 4)); end
        tick();
    endtask

    task automatic test_reset_mid();
        int nb;
        launch({16{4'hF}}, 16'hFFFF);
        for (int i = 0; i < 7; i++) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
        clear = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_done got=%b exp=0", done); end
        checks++; if (y_flat !== '0) begin errors++; $display("FAIL mid_y got=%h exp=0", y_flat); end
        clear = 1'b1;
        tick();
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_idle got=busy%b/done%b exp=0/0", busy, done); end
        launch({4{16'h1234}}, 16'h1111);
        count_busy(nb);
        checks++; if (nb !== 16) begin errors++; $display("FAIL mid_fresh_len got=%0d exp=16", nb); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL mid_fresh_done got=%b exp=1", done); end
        checks++; if (y_flat !== pack_y(10, 10, 10, 10)) begin errors++; $display("FAIL mid_fresh_y got=%h exp=%h", y_flat, pack_y(10, 10, 10, 10)); end
        tick();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_max();
        test_isolation();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
